sim_test_ctrl: RTL and testbench

Parametrised simulation controller for the Kasumi pipeline test benches. It generalises the fixed-step clock loop and single-hart tohost snoop to NUM_HARTS independent data-memory write channels. It decodes riscv-tests tohost reports, enforces a cycle budget, drains the pipeline and freezes it. It sits beside the core(s) and test memories and drives the pipeline stop input plus bench-visible pass/fail status.

---
 rtl/sim_test_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_sim_test_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_test_ctrl.sv
// Simulation controller: snoops per-hart tohost writes, enforces a cycle budget,
// drains the pipeline after the last report and then freezes it with sticky status.
module sim_test_ctrl #(
   parameter int                NUM_HARTS    = 1,
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 32'h0000_1000,
   parameter int                MAX_STEP     = 10000,
   parameter int                DRAIN_CYCLES = 4,
   parameter int                CNT_W        = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_HARTS-1:0]          wr_en,
   input  logic [NUM_HARTS*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_HARTS*DATA_W-1:0]   wr_data,
   output logic                          stop,
   output logic                          done,
   output logic                          pass,
   output logic                          timeout,
   output logic [NUM_HARTS-1:0]          hart_done,
   output logic [NUM_HARTS-1:0]          hart_fail,
   output logic [DATA_W-1:0]             fail_code,
   output logic [CNT_W-1:0]              cycle_count
);

   localparam int DRAIN_W    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [NUM_HARTS-1:0] hart_done_r;
   logic [NUM_HARTS-1:0] hart_fail_r;
   logic [DATA_W-1:0]    fail_code_r;
   logic [CNT_W-1:0]     cycle_count_r;
   logic [DRAIN_W-1:0]   drain_cnt_r;
   logic                 stop_r;
   logic                 done_r;
   logic                 pass_r;
   logic                 timeout_r;

   logic                 accept_s;
   logic [NUM_HARTS-1:0] new_rep_s;
   logic [NUM_HARTS-1:0] new_fail_s;
   logic [NUM_HARTS-1:0] hart_done_s;
   logic [NUM_HARTS-1:0] hart_fail_s;
   logic [DATA_W-1:0]    fail_code_s;
   logic                 all_done_s;
   logic                 budget_end_s;
   logic                 drain_last_s;
   logic [CNT_W-1:0]     cycle_count_s;
   logic [DRAIN_W-1:0]   drain_cnt_s;
   logic                 stop_s;
   logic                 done_s;
   logic                 pass_s;
   logic                 timeout_s;

   // Report decode: only the first tohost report with bit0 set counts per hart.
   always_comb begin
      accept_s    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
      new_rep_s   = '0;
      new_fail_s  = '0;
      fail_code_s = fail_code_r;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (accept_s && wr_en[h] && !hart_done_r[h] &&
             (wr_addr[h*ADDR_W +: ADDR_W] == TOHOST_ADDR) && wr_data[h*DATA_W]) begin
            new_rep_s[h]  = 1'b1;
            new_fail_s[h] = (wr_data[h*DATA_W +: DATA_W] != DATA_W'(1));
         end else begin
            new_rep_s[h]  = 1'b0;
            new_fail_s[h] = 1'b0;
         end
      end
      // Descending scan so the lowest failing hart is the one that sticks.
      if (hart_fail_r == '0) begin
         for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (new_fail_s[h]) begin
               fail_code_s = wr_data[h*DATA_W +: DATA_W] >> 1;
            end else begin
               fail_code_s = fail_code_s;
            end
         end
      end else begin
         fail_code_s = fail_code_r;
      end
      hart_done_s  = hart_done_r | new_rep_s;
      hart_fail_s  = hart_fail_r | new_fail_s;
      all_done_s   = &hart_done_s;
      budget_end_s = (cycle_count_r == CNT_W'(MAX_STEP - 1));
      drain_last_s = (drain_cnt_r == DRAIN_W'(DRAIN_LAST));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; a final report on the budget's last cycle beats the timeout.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:  state_s = ST_RUN;
         ST_RUN: begin
            if (all_done_s) begin
               state_s = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
            end else if (budget_end_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_DONE:  state_s = ST_DONE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Output and counter next values, derived from the upcoming state.
   always_comb begin
      stop_s      = 1'b1;
      done_s      = 1'b0;
      timeout_s   = timeout_r;
      drain_cnt_s = '0;
      case (state_s)
         ST_IDLE:  stop_s = 1'b1;
         ST_RUN:   stop_s = 1'b0;
         ST_DRAIN: stop_s = 1'b0;
         ST_DONE: begin
            stop_s = 1'b1;
            done_s = 1'b1;
         end
         default:  stop_s = 1'b1;
      endcase
      if ((state_r == ST_RUN) && (state_s == ST_DONE) && !all_done_s) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = timeout_r;
      end
      pass_s = done_s && (hart_fail_s == '0) && !timeout_s;
      if (accept_s && (cycle_count_r != {CNT_W{1'b1}})) begin
         cycle_count_s = cycle_count_r + CNT_W'(1);
      end else begin
         cycle_count_s = cycle_count_r;
      end
      if (state_r == ST_DRAIN) begin
         drain_cnt_s = drain_cnt_r + DRAIN_W'(1);
      end else begin
         drain_cnt_s = '0;
      end
   end

   // Status and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hart_done_r   <= '0;
         hart_fail_r   <= '0;
         fail_code_r   <= '0;
         cycle_count_r <= '0;
         drain_cnt_r   <= '0;
         stop_r        <= 1'b1;
         done_r        <= 1'b0;
         pass_r        <= 1'b0;
         timeout_r     <= 1'b0;
      end else begin
         hart_done_r   <= hart_done_s;
         hart_fail_r   <= hart_fail_s;
         fail_code_r   <= fail_code_s;
         cycle_count_r <= cycle_count_s;
         drain_cnt_r   <= drain_cnt_s;
         stop_r        <= stop_s;
         done_r        <= done_s;
         pass_r        <= pass_s;
         timeout_r     <= timeout_s;
      end
   end

   assign stop        = stop_r;
   assign done        = done_r;
   assign pass        = pass_r;
   assign timeout     = timeout_r;
   assign hart_done   = hart_done_r;
   assign hart_fail   = hart_fail_r;
   assign fail_code   = fail_code_r;
   assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_sim_test_ctrl.sv
// Bench for sim_test_ctrl: a single-hart instance (MAX_STEP=100) and a four-hart
// instance; final status of each run is queued as expected and checked when done rises.
module tb_sim_test_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst1_n;
   logic [0:0]   wr_en1;
   logic [31:0]  wr_addr1, wr_data1;
   logic         stop1, done1, pass1, timeout1;
   logic [0:0]   hd1, hf1;
   logic [31:0]  fc1, cc1;

   logic         rst4_n;
   logic [3:0]   wr_en4;
   logic [127:0] wr_addr4, wr_data4;
   logic         stop4, done4, pass4, timeout4;
   logic [3:0]   hd4, hf4;
   logic [31:0]  fc4, cc4;

   typedef struct packed {
      logic        done;
      logic        pass;
      logic        tmo;
      logic [3:0]  hd;
      logic [3:0]  hf;
      logic [31:0] fc;
      logic [31:0] cc;
   } exp_t;

   exp_t sb1_q[$];
   exp_t sb4_q[$];
   exp_t exp1, got1, exp4, got4;
   int   tests_run = 0;
   int   tests_failed = 0;

   sim_test_ctrl #(.NUM_HARTS(1), .MAX_STEP(100)) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .stop(stop1), .done(done1), .pass(pass1), .timeout(timeout1),
      .hart_done(hd1), .hart_fail(hf1), .fail_code(fc1), .cycle_count(cc1));

   sim_test_ctrl #(.NUM_HARTS(4), .MAX_STEP(200)) u_dut4 (
      .clk(clk), .rst_n(rst4_n), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
      .stop(stop4), .done(done4), .pass(pass4), .timeout(timeout4),
      .hart_done(hd4), .hart_fail(hf4), .fail_code(fc4), .cycle_count(cc4));

   function automatic exp_t mk_exp(input logic p, input logic t, input logic [3:0] hd,
                                   input logic [3:0] hf, input logic [31:0] fc,
                                   input logic [31:0] cc);
      exp_t e;
      e.done = 1'b1; e.pass = p; e.tmo = t; e.hd = hd; e.hf = hf; e.fc = fc; e.cc = cc;
      return e;
   endfunction

   // Scoreboard for the single-hart run: pop and compare when done rises.
   initial forever begin
      @(posedge done1);
      #1;
      tests_run++;
      if (sb1_q.size() == 0) begin
         tests_failed++;
         $display("FAIL sb1_unexpected_done got=done required=no pending run");
      end else begin
         exp1 = sb1_q.pop_front();
         got1.done = done1; got1.pass = pass1; got1.tmo = timeout1;
         got1.hd = {3'b000, hd1}; got1.hf = {3'b000, hf1}; got1.fc = fc1; got1.cc = cc1;
         if (got1 !== exp1) begin
            tests_failed++;
            $display("FAIL sb1_final got=%h required=%h", got1, exp1);
         end
      end
   end

   // Scoreboard for the four-hart run.
   initial forever begin
      @(posedge done4);
      #1;
      tests_run++;
      if (sb4_q.size() == 0) begin
         tests_failed++;
         $display("FAIL sb4_unexpected_done got=done required=no pending run");
      end else begin
         exp4 = sb4_q.pop_front();
         got4.done = done4; got4.pass = pass4; got4.tmo = timeout4;
         got4.hd = hd4; got4.hf = hf4; got4.fc = fc4; got4.cc = cc4;
         if (got4 !== exp4) begin
            tests_failed++;
            $display("FAIL sb4_final got=%h required=%h", got4, exp4);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reset1();
      rst1_n = 1'b0; wr_en1 = 1'b0; wr_addr1 = 32'h0; wr_data1 = 32'h0;
      tick(2);
      rst1_n = 1'b1;
   endtask

   task automatic reset4();
      rst4_n = 1'b0; wr_en4 = 4'h0; wr_addr4 = 128'h0; wr_data4 = 128'h0;
      tick(2);
      rst4_n = 1'b1;
   endtask

   task automatic write4(input logic [3:0] en, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
      wr_en4   = en;
      wr_addr4 = {32'h0000_1000, 32'h0000_1000, 32'h0000_1000, a0};
      wr_data4 = {d3, d2, d1, d0};
   endtask

   task automatic wait_done1(input int budget);
      int k = 0;
      while (done1 !== 1'b1 && k < budget) begin tick(1); k++; end
      tests_run++;
      if (done1 !== 1'b1) begin tests_failed++; $display("FAIL wait_done1 got=%b required=1", done1); end
   endtask

   task automatic wait_done4(input int budget);
      int k = 0;
      while (done4 !== 1'b1 && k < budget) begin tick(1); k++; end
      tests_run++;
      if (done4 !== 1'b1) begin tests_failed++; $display("FAIL wait_done4 got=%b required=1", done4); end
   endtask

   task automatic test_reset();
      rst1_n = 1'b0; rst4_n = 1'b0;
      wr_en1 = 1'b0; wr_addr1 = 32'h0; wr_data1 = 32'h0;
      write4(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick(2);
      tests_run++;
      if ({stop1, done1, pass1, timeout1, hd1, hf1} !== 6'b100000) begin
         tests_failed++; $display("FAIL reset_flags1 got=%b required=100000", {stop1, done1, pass1, timeout1, hd1, hf1});
      end
      tests_run++;
      if ({fc1, cc1} !== 64'h0) begin tests_failed++; $display("FAIL reset_counts1 got=%h required=0", {fc1, cc1}); end
      tests_run++;
      if ({stop4, done4, hd4, hf4, fc4, cc4} !== {2'b10, 72'h0}) begin
         tests_failed++; $display("FAIL reset_dut4 got=%h required=%h", {stop4, done4, hd4, hf4, fc4, cc4}, {2'b10, 72'h0});
      end
      rst1_n = 1'b1;
      tick(1);
      tests_run++;
      if ({stop1, cc1} !== 33'h0) begin tests_failed++; $display("FAIL idle_to_run got=%h required=0", {stop1, cc1}); end
      tick(1);
      tests_run++;
      if (cc1 !== 32'd1) begin tests_failed++; $display("FAIL first_count got=%0d required=1", cc1); end
   endtask

   task automatic test_pass_single();
      reset1();
      tick(51);
      tests_run++;
      if ({stop1, cc1} !== {1'b0, 32'd50}) begin tests_failed++; $display("FAIL pass_pre got=%h required=%h", {stop1, cc1}, {1'b0, 32'd50}); end
      sb1_q.push_back(mk_exp(1'b1, 1'b0, 4'b0001, 4'b0000, 32'd0, 32'd55));
      wr_en1 = 1'b1; wr_addr1 = 32'h0000_1000; wr_data1 = 32'h1;
      tick(1);
      wr_en1 = 1'b0;
      tests_run++;
      if ({hd1, done1, cc1} !== {2'b10, 32'd51}) begin tests_failed++; $display("FAIL pass_report got=%h required=%h", {hd1, done1, cc1}, {2'b10, 32'd51}); end
      tick(3);
      tests_run++;
      if ({done1, stop1} !== 2'b00) begin tests_failed++; $display("FAIL pass_drain got=%b required=00", {done1, stop1}); end
      tick(1);
      tests_run++;
      if ({done1, stop1, pass1} !== 3'b111) begin tests_failed++; $display("FAIL pass_done got=%b required=111", {done1, stop1, pass1}); end
      tick(3);
      tests_run++;
      if (cc1 !== 32'd55) begin tests_failed++; $display("FAIL pass_frozen_count got=%0d required=55", cc1); end
   endtask

   task automatic test_fail_single();
      reset1();
      tick(10);
      sb1_q.push_back(mk_exp(1'b0, 1'b0, 4'b0001, 4'b0001, 32'd3, 32'd14));
      wr_en1 = 1'b1; wr_addr1 = 32'h0000_1000; wr_data1 = 32'h0000_0007;
      tick(1);
      wr_data1 = 32'h1;
      tick(1);
      wr_en1 = 1'b0;
      tests_run++;
      if ({hf1, fc1} !== {1'b1, 32'd3}) begin tests_failed++; $display("FAIL fail_latch got=%h required=%h", {hf1, fc1}, {1'b1, 32'd3}); end
      wait_done1(20);
      wr_en1 = 1'b1; wr_data1 = 32'h1;
      tick(2);
      wr_en1 = 1'b0;
      tests_run++;
      if ({hd1, hf1, pass1, fc1, cc1} !== {3'b110, 32'd3, 32'd14}) begin
         tests_failed++; $display("FAIL fail_frozen got=%h required=%h", {hd1, hf1, pass1, fc1, cc1}, {3'b110, 32'd3, 32'd14});
      end
   endtask

   task automatic test_timeout();
      reset1();
      tick(100);
      tests_run++;
      if ({done1, stop1, cc1} !== {2'b00, 32'd99}) begin tests_failed++; $display("FAIL timeout_pre got=%h required=%h", {done1, stop1, cc1}, {2'b00, 32'd99}); end
      sb1_q.push_back(mk_exp(1'b0, 1'b1, 4'b0000, 4'b0000, 32'd0, 32'd100));
      tick(1);
      tests_run++;
      if ({done1, timeout1, stop1, pass1} !== 4'b1110) begin tests_failed++; $display("FAIL timeout_edge got=%b required=1110", {done1, timeout1, stop1, pass1}); end
      tick(3);
      tests_run++;
      if (cc1 !== 32'd100) begin tests_failed++; $display("FAIL timeout_hold got=%0d required=100", cc1); end
   endtask

   task automatic test_ignored_and_last_cycle();
      reset1();
      tick(5);
      wr_en1 = 1'b1; wr_addr1 = 32'h0000_1000; wr_data1 = 32'h2;
      tick(1);
      wr_addr1 = 32'h0000_1004; wr_data1 = 32'h1;
      tick(1);
      wr_en1 = 1'b0;
      tick(1);
      tests_run++;
      if ({hd1, stop1} !== 2'b00) begin tests_failed++; $display("FAIL ignored_writes got=%b required=00", {hd1, stop1}); end
      tick(92);
      tests_run++;
      if (cc1 !== 32'd99) begin tests_failed++; $display("FAIL last_cycle_pre got=%0d required=99", cc1); end
      sb1_q.push_back(mk_exp(1'b1, 1'b0, 4'b0001, 4'b0000, 32'd0, 32'd104));
      wr_en1 = 1'b1; wr_addr1 = 32'h0000_1000; wr_data1 = 32'h1;
      tick(1);
      wr_en1 = 1'b0;
      tests_run++;
      if ({hd1, done1, timeout1, stop1} !== 4'b1000) begin tests_failed++; $display("FAIL last_cycle_report got=%b required=1000", {hd1, done1, timeout1, stop1}); end
      wait_done1(10);
   endtask

   task automatic test_multi_hart();
      reset4();
      tick(20);
      write4(4'b0111, 32'h0000_1004, 32'h1, 32'd5, 32'd9, 32'h0);
      tick(1);
      wr_en4 = 4'h0;
      tests_run++;
      if ({hd4, hf4, fc4, done4} !== {4'b0110, 4'b0110, 32'd2, 1'b0}) begin
         tests_failed++; $display("FAIL multi_first got=%h required=%h", {hd4, hf4, fc4, done4}, {4'b0110, 4'b0110, 32'd2, 1'b0});
      end
      tick(1);
      sb4_q.push_back(mk_exp(1'b0, 1'b0, 4'b1111, 4'b0110, 32'd2, 32'd26));
      write4(4'b1011, 32'h0000_1000, 32'h1, 32'd3, 32'h0, 32'h1);
      tick(1);
      wr_en4 = 4'h0;
      tests_run++;
      if ({hd4, hf4, fc4} !== {4'b1111, 4'b0110, 32'd2}) begin
         tests_failed++; $display("FAIL multi_final got=%h required=%h", {hd4, hf4, fc4}, {4'b1111, 4'b0110, 32'd2});
      end
      wait_done4(10);
   endtask

   task automatic test_back_to_back();
      reset4();
      tick(3);
      sb4_q.push_back(mk_exp(1'b1, 1'b0, 4'b1111, 4'b0000, 32'd0, 32'd7));
      write4(4'b1111, 32'h0000_1000, 32'h1, 32'h1, 32'h1, 32'h1);
      tick(1);
      wr_en4 = 4'h0;
      tests_run++;
      if ({hd4, stop4} !== 5'b11110) begin tests_failed++; $display("FAIL all_harts got=%b required=11110", {hd4, stop4}); end
      wait_done4(10);
   endtask

   task automatic test_reset_mid_drain();
      reset1();
      tick(51);
      wr_en1 = 1'b1; wr_addr1 = 32'h0000_1000; wr_data1 = 32'h1;
      tick(1);
      wr_en1 = 1'b0;
      tick(2);
      #2 rst1_n = 1'b0;
      #1;
      tests_run++;
      if ({stop1, done1, pass1, timeout1, hd1, hf1, fc1, cc1} !== {6'b100000, 64'h0}) begin
         tests_failed++; $display("FAIL async_reset got=%h required=%h", {stop1, done1, pass1, timeout1, hd1, hf1, fc1, cc1}, {6'b100000, 64'h0});
      end
      test_pass_single();
   endtask

   initial begin
      test_reset();
      test_pass_single();
      test_fail_single();
      test_timeout();
      test_ignored_and_last_cycle();
      test_multi_hart();
      test_back_to_back();
      test_reset_mid_drain();
      tick(3);
      tests_run++;
      if (sb1_q.size() + sb4_q.size() != 0) begin
         tests_failed++; $display("FAIL sb_drained got=%0d required=0", sb1_q.size() + sb4_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
